// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle.
// master drives operands and start; slave returns status and results.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Flags;

  modport master (
    output start, ALUControl, a, b,
    input  busy, done, Result, Flags
  );

  modport slave (
    input  start, ALUControl, a, b,
    output busy, done, Result, Flags
  );
endinterface

// File: rtl/alu_multicycle.sv
// Single-cycle ADD/SUB/logic ALU with iterative shift-add MUL.
// Define ALU_MULTICYCLE_DIV_EN to add an iterative restoring divider.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  alu_multicycle_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
`ifdef ALU_MULTICYCLE_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b110;
`endif

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_done;
`ifdef ALU_MULTICYCLE_DIV_EN
  logic             r_div;
`endif

  logic             w_sub;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res1;
  logic             w_c1;
  logic             w_v1;
  logic [3:0]       w_flg1;
  logic             w_is_div;
  logic             w_multi;

  logic [WIDTH:0]   w_psum;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;
  logic             w_c2;
  logic             w_v2;
  logic [3:0]       w_flg2;
`ifdef ALU_MULTICYCLE_DIV_EN
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
`endif

`ifdef ALU_MULTICYCLE_DIV_EN
  assign w_is_div = bus.ALUControl == OP_DIV;
`else
  assign w_is_div = 1'b0;
`endif
  assign w_multi = (bus.ALUControl == OP_MUL) || w_is_div;

  // SUB is a + ~b + 1 so C reads as "no borrow"
  always_comb begin
    w_sub  = bus.ALUControl == OP_SUB;
    w_bop  = w_sub ? ~bus.b : bus.b;
    w_sum  = {1'b0, bus.a} + {1'b0, w_bop}
           + {{WIDTH{1'b0}}, w_sub};
    w_res1 = '0;
    w_c1   = 1'b0;
    w_v1   = 1'b0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: begin
        w_res1 = w_sum[WIDTH-1:0];
        w_c1   = w_sum[WIDTH];
        w_v1   = (bus.a[WIDTH-1] == w_bop[WIDTH-1])
              && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_res1 = bus.a & bus.b;
      OP_OR:  w_res1 = bus.a | bus.b;
      OP_XOR: w_res1 = bus.a ^ bus.b;
      default: w_res1 = '0;
    endcase
    w_flg1 = {w_res1[WIDTH-1], w_res1 == '0, w_c1, w_v1};
  end

  // {r_hi, r_lo} shifts right; r_lo starts as the multiplier
  always_comb begin
    w_psum = {1'b0, r_hi}
           + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_nhi  = w_psum[WIDTH:1];
    w_nlo  = {w_psum[0], r_lo[WIDTH-1:1]};
    w_c2   = |w_nhi;
    w_v2   = 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_a};
    w_ge    = w_shift >= {1'b0, r_a};
    if (r_div) begin
      w_nhi = w_ge ? w_trial[WIDTH-1:0]
                   : w_shift[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_ge};
      w_c2  = 1'b0;
      w_v2  = r_a == '0;
    end
`endif
    w_flg2 = {w_nlo[WIDTH-1], w_nlo == '0, w_c2, w_v2};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
      r_div    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start && w_multi) begin
          r_state <= RUN;
          r_cnt   <= '0;
          r_hi    <= '0;
          r_a     <= w_is_div ? bus.b : bus.a;
          r_lo    <= w_is_div ? bus.a : bus.b;
`ifdef ALU_MULTICYCLE_DIV_EN
          r_div   <= w_is_div;
`endif
        end else if (bus.start) begin
          r_result <= w_res1;
          r_flags  <= w_flg1;
          r_done   <= 1'b1;
        end
      end else begin
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_result <= w_nlo;
          r_flags  <= w_flg2;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy   = r_state == RUN;
  assign bus.done   = r_done;
  assign bus.Result = r_result;
  assign bus.Flags  = r_flags;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32 and WIDTH=8 instances).
// Define ALU_MULTICYCLE_DIV_EN to also exercise the divider.
module tb_alu_multicycle;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  exp_t q[$];

  alu_multicycle_if #(.WIDTH(32)) bus();
  alu_multicycle_if #(.WIDTH(8))  bus8();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t        e;
    logic [63:0] p;
    longint      s;
    logic        c;
    logic        v;
    e.res = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        p = {32'h0, a} + {32'h0, b};
        e.res = p[31:0];
        c = p[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        e.res = a - b;
        c = a >= b;
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin
        p = {32'h0, a} * {32'h0, b};
        e.res = p[31:0];
        c = p[63:32] != 32'h0;
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      3'd6: begin
        if (b == 32'h0) begin
          e.res = 32'hFFFF_FFFF;
          v = 1'b1;
        end else begin
          e.res = a / b;
        end
      end
`endif
      default: e.res = '0;
    endcase
    e.flg = {e.res[31], e.res == 32'h0, c, v};
    return e;
  endfunction

  // Issues one op, optionally pokes a stray start while busy,
  // then waits (bounded) for done.
  task automatic drive(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  int          poke,
    output int          lat,
    output int          bcnt,
    output bit          seen
  );
    @(negedge clk);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.a          = a;
    bus.b          = b;
    q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) bcnt++;
      if (poke != 0 && lat == poke) begin
        @(negedge clk);
        bus.start      = 1'b1;
        bus.ALUControl = 3'd0;
        bus.a          = 32'd1;
        bus.b          = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      lat++;
    end
    seen = bus.done;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.ALUControl = '0;
    bus.a = '0;
    bus.b = '0;
    bus8.start = 1'b0;
    bus8.ALUControl = '0;
    bus8.a = '0;
    bus8.b = '0;
    #2;
    n_vec++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_status got %b want 00",
               {bus.busy, bus.done});
    end
    n_vec++;
    if ({bus.Result, bus.Flags} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_regs got %h/%b want 0/0",
               bus.Result, bus.Flags);
    end
    n_vec++;
    if ({bus8.busy, bus8.done, bus8.Result, bus8.Flags} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_w8 got %h want 0",
               {bus8.busy, bus8.done, bus8.Result, bus8.Flags});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_addsub;
    logic [2:0]  ops[6];
    logic [31:0] av[6];
    logic [31:0] bv[6];
    int lat, bc;
    bit seen;
    exp_t e;
    ops = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0};
    av  = '{32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
            32'd3, 32'h8000_0000, 32'h8000_0000};
    bv  = '{32'd5, 32'd1, 32'd1,
            32'd5, 32'd1, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], av[i], bv[i], 0, lat, bc, seen);
      e = q.pop_front();
      n_vec++;
      if (!seen || lat != 0 || bc != 0) begin
        n_err++;
        $display("FAIL addsub_lat[%0d] got lat=%0d busy=%0d want 0/0",
                 i, lat, bc);
      end
      n_vec++;
      if (bus.Result !== e.res || bus.Flags !== e.flg) begin
        n_err++;
        $display("FAIL addsub[%0d] got %h/%b want %h/%b",
                 i, bus.Result, bus.Flags, e.res, e.flg);
      end
    end
  endtask

  task automatic test_logic;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int lat, bc;
    bit seen;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      op = (i < 6) ? 3'(2 + i % 3) : 3'd7;
`ifndef ALU_MULTICYCLE_DIV_EN
      if (i == 7) op = 3'd6;
`endif
      a = $urandom;
      b = (i == 0) ? ~a : $urandom;
      drive(op, a, b, 0, lat, bc, seen);
      e = q.pop_front();
      n_vec++;
      if (!seen || lat != 0 || bus.Result !== e.res
          || bus.Flags !== e.flg) begin
        n_err++;
        $display("FAIL logic[%0d] op=%0d got %h/%b lat=%0d want %h/%b",
                 i, op, bus.Result, bus.Flags, lat, e.res, e.flg);
      end
    end
  endtask

  task automatic test_mul;
    logic [31:0] av[4];
    logic [31:0] bv[4];
    logic [31:0] hold;
    int lat, bc;
    bit seen;
    exp_t e;
    av = '{32'h1_0000, 32'd12, 32'hFFFF_FFFF, 32'h0};
    bv = '{32'h1_0000, 32'd11, 32'h3, 32'h1234};
    for (int i = 0; i < 4; i++) begin
      drive(3'd5, av[i], bv[i], (i == 0) ? 5 : 0, lat, bc, seen);
      e = q.pop_front();
      n_vec++;
      if (!seen || lat != 32 || bc != 32) begin
        n_err++;
        $display("FAIL mul_lat[%0d] got lat=%0d busy=%0d want 32/32",
                 i, lat, bc);
      end
      n_vec++;
      if (bus.Result !== e.res || bus.Flags !== e.flg) begin
        n_err++;
        $display("FAIL mul[%0d] got %h/%b want %h/%b",
                 i, bus.Result, bus.Flags, e.res, e.flg);
      end
      hold = bus.Result;
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0
          || bus.Result !== hold) begin
        n_err++;
        $display("FAIL mul_hold[%0d] got done=%b busy=%b %h want 0/0/%h",
                 i, bus.done, bus.busy, bus.Result, hold);
      end
    end
  endtask

  task automatic test_mul8;
    logic [7:0] av[2];
    logic [7:0] bv[2];
    int lat;
    exp_t e;
    av = '{8'd12, 8'd200};
    bv = '{8'd11, 8'd3};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.ALUControl = 3'd5;
      bus8.a = av[i];
      bus8.b = bv[i];
      if (i == 0) q.push_back('{32'h84, 4'b1000});
      else q.push_back('{32'h58, 4'b0010});
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      lat = 0;
      while (!bus8.done && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      e = q.pop_front();
      n_vec++;
      if (lat != 8 || bus8.Result !== e.res[7:0]
          || bus8.Flags !== e.flg) begin
        n_err++;
        $display("FAIL mul8[%0d] got %h/%b lat=%0d want %h/%b lat=8",
                 i, bus8.Result, bus8.Flags, lat, e.res[7:0], e.flg);
      end
    end
  endtask

  task automatic test_div;
`ifdef ALU_MULTICYCLE_DIV_EN
    logic [31:0] av[4];
    logic [31:0] bv[4];
    int lat, bc;
    bit seen;
    exp_t e;
    av = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd5};
    bv = '{32'd7, 32'd0, 32'd3, 32'd9};
    for (int i = 0; i < 4; i++) begin
      drive(3'd6, av[i], bv[i], 0, lat, bc, seen);
      e = q.pop_front();
      n_vec++;
      if (!seen || lat != 32 || bus.Result !== e.res
          || bus.Flags !== e.flg) begin
        n_err++;
        $display("FAIL div[%0d] got %h/%b lat=%0d want %h/%b lat=32",
                 i, bus.Result, bus.Flags, lat, e.res, e.flg);
      end
    end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.ALUControl = 3'd0;
    bus.a = 32'd10;
    bus.b = 32'd20;
    q.push_back(model(3'd0, 32'd10, 32'd20));
    @(posedge clk);
    #1;
    e = q.pop_front();
    n_vec++;
    if (bus.done !== 1'b1 || bus.Result !== e.res) begin
      n_err++;
      $display("FAIL b2b_add got done=%b %h want 1/%h",
               bus.done, bus.Result, e.res);
    end
    bus.ALUControl = 3'd4;
    bus.a = 32'hF0F0_1234;
    bus.b = 32'h0FF0_FFFF;
    q.push_back(model(3'd4, bus.a, bus.b));
    @(posedge clk);
    #1;
    e = q.pop_front();
    n_vec++;
    if (bus.done !== 1'b1 || bus.Result !== e.res
        || bus.Flags !== e.flg) begin
      n_err++;
      $display("FAIL b2b_xor got done=%b %h/%b want 1/%h/%b",
               bus.done, bus.Result, bus.Flags, e.res, e.flg);
    end
    bus.ALUControl = 3'd5;
    bus.a = 32'd3;
    bus.b = 32'd5;
    q.push_back(model(3'd5, 32'd3, 32'd5));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = q.pop_front();
    n_vec++;
    if (lat != 32 || bus.Result !== e.res || bus.Flags !== e.flg) begin
      n_err++;
      $display("FAIL b2b_mul got %h/%b lat=%0d want %h/%b lat=32",
               bus.Result, bus.Flags, lat, e.res, e.flg);
    end
  endtask

  task automatic test_reset_abort;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.ALUControl = 3'd5;
    bus.a = 32'd7;
    bus.b = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0
        || bus.Result !== 32'h0 || bus.Flags !== 4'h0) begin
      n_err++;
      $display("FAIL abort_async got busy=%b done=%b %h/%b want 0/0/0/0",
               bus.busy, bus.done, bus.Result, bus.Flags);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL abort_quiet got %0d active cycles want 0", pulses);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1;
    bus.ALUControl = 3'd0;
    bus.a = 32'd2;
    bus.b = 32'd3;
    q.push_back('{32'd5, 4'b0000});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_vec++;
    if (bus.done !== 1'b1 || bus.Result !== q[0].res
        || bus.Flags !== q[0].flg) begin
      n_err++;
      $display("FAIL abort_restart got done=%b %h/%b want 1/%h/%b",
               bus.done, bus.Result, bus.Flags, q[0].res, q[0].flg);
    end
    void'(q.pop_front());
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_addsub();
    test_logic();
    test_mul();
    test_mul8();
    test_div();
    test_back_to_back();
    test_reset_abort();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal values 8..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port ALUControl  input  3  operation select, sampled with start.
REQ-006 SHALL have ports a, b  input  WIDTH  operands, sampled with start.
REQ-007 SHALL have port busy  output  1  high while an operation is in flight.
REQ-008 SHALL have port done  output  1  one-cycle pulse when Result/Flags are updated.
REQ-009 SHALL have port Result  output  WIDTH  registered result.
REQ-010 SHALL have port Flags  output  4  registered {N, Z, C, V}.

Function
REQ-011 Encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV (only with macro), 111 reserved.
REQ-012 FSM states SHALL be IDLE, RUN; IDLE->RUN on start for MUL/DIV, RUN->IDLE when iteration counter reaches WIDTH-1; busy=1 exactly in RUN.
REQ-013 Start with busy=0 SHALL latch ALUControl, a, b on that edge; start while busy=1 SHALL be ignored with no side effect.
REQ-014 ADD/SUB/AND/OR/XOR SHALL complete in one cycle: accepted at edge k, Result/Flags/done valid after edge k+1... stated precisely: done=1 in the cycle after the accepting edge, busy never asserted.
REQ-015 SUB SHALL compute a + ~b + 1 in WIDTH+1 bits; ADD a + b.
REQ-016 N SHALL be Result[WIDTH-1], Z SHALL be (Result==0) for every operation.
REQ-017 C SHALL be carry-out bit WIDTH for ADD/SUB (SUB: 1 means no borrow), 0 otherwise.
REQ-018 V SHALL be signed overflow for ADD/SUB: operand signs (b inverted for SUB) equal and sum sign differs; 0 for logic ops and MUL.
REQ-019 MUL SHALL be unsigned shift-add, one multiplier bit per cycle, WIDTH iterations; Result = low WIDTH bits of a*b; C=1 iff high WIDTH bits nonzero.
REQ-020 MUL/DIV done SHALL pulse WIDTH+1 cycles after the accepting edge (WIDTH cycles busy, done in the cycle after busy falls).
REQ-021 Reserved code 111 SHALL complete in one cycle with Result=0, Flags=4'b0100.
REQ-022 Result and Flags SHALL hold their last value between completions; done SHALL be high for exactly one cycle per accepted operation.
REQ-023 start asserted in the same cycle done pulses (busy=0) SHALL be accepted, giving back-to-back operation.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, busy=0, done=0, Result=0, Flags=0, counter=0, regardless of clock.
REQ-025 reset during RUN SHALL abort the operation with no done pulse; first edge after deassertion SHALL accept start normally.

Configuration
REQ-026 Macro ALU_MULTICYCLE_DIV_EN defined SHALL compile in unsigned restoring divide for code 110: one quotient bit per cycle, WIDTH iterations, latency per REQ-020, Result=quotient, C=0, V=0.
REQ-027 With ALU_MULTICYCLE_DIV_EN, b=0 SHALL return Result=all ones, V=1, C=0, same latency.
REQ-028 Without ALU_MULTICYCLE_DIV_EN, code 110 SHALL behave as reserved (REQ-021) and no divider logic SHALL be synthesised.

Verification
REQ-029 WIDTH=32, SUB a=5 b=5 -> next cycle done=1, Result=0, Flags=0110.
REQ-030 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> Result=0x80000000, Flags=1001; ADD a=0xFFFFFFFF b=1 -> Result=0, Flags=0110.
REQ-031 WIDTH=32, MUL a=0x10000 b=0x10000 -> busy 32 cycles, done at cycle 33, Result=0, Flags=0110; second start during busy ignored.
REQ-032 WIDTH=8, MUL a=12 b=11 -> done 9 cycles after accept, Result=132 (0x84), Flags=1000.
REQ-033 DIV_EN, WIDTH=32, DIV a=100 b=7 -> Result=14, Flags=0000; DIV b=0 -> Result=0xFFFFFFFF, Flags=1001.
REQ-034 MUL started, reset pulsed at cycle 10 -> busy=0, Result=0, no done; new ADD 2+3 after release -> Result=5, Flags=0000.
